// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and
// hands {pc, inst} to decode over a valid/allowin handshake.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_zip,
  output logic        fs2ds_valid,
  output logic [63:0] fs2ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        started;
  logic        fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] fs_pc;
  logic        br_pend;
  logic [31:0] br_target_r;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic [31:0] nextpc;
  logic [31:0] inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        handoff;

  assign br_taken    = br_zip[32];
  assign br_target   = br_zip[31:0];
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs2ds_valid = fs_valid & fs_ready_go;
  assign handoff     = fs2ds_valid & ds_allowin;

  assign inst_sram_en    = started & fs_allowin;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  // a live branch outranks an older pending redirect
  always_comb begin
    nextpc = fs_pc + 32'd4;
    priority case (1'b1)
      br_taken: nextpc = br_target;
      br_pend:  nextpc = br_target_r;
      default:  nextpc = fs_pc + 32'd4;
    endcase
  end

  assign inst      = buf_valid ? inst_buf : inst_sram_rdata;
  assign fs2ds_bus = {fs_pc, inst};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - 32'd4;
      br_pend     <= 1'b0;
      br_target_r <= 32'b0;
    end else if (inst_sram_en) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
      br_pend  <= 1'b0;
    end else if (br_taken) begin
      br_pend     <= 1'b1;
      br_target_r <= br_target;
      fs_valid    <= 1'b0;
    end else if (fs_valid & ds_allowin) begin
      fs_valid <= 1'b0;
    end
  end

  // SRAM data lives one cycle only; park it while decode stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else if (handoff | br_taken) begin
      buf_valid <= 1'b0;
    end else if (fs_valid & ~ds_allowin & ~buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed stimulus, SRAM model and a queue-based
// scoreboard checking every decode handoff.
module tb_if_stage;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_zip;
  logic        fs2ds_valid;
  logic [63:0] fs2ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [63:0] q[$];

  if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (ds_allowin),
    .br_zip          (br_zip),
    .fs2ds_valid     (fs2ds_valid),
    .fs2ds_bus       (fs2ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return a ^ 32'h5a5a5a5a;
  endfunction

  // synchronous SRAM; junk on the bus when not read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else inst_sram_rdata <= 32'hdead0000 | cyc;
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    q.push_back({pc, mem(pc)});
  endtask

  always @(negedge clk) begin
    if (resetn && fs2ds_valid && ds_allowin) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL handoff_unexpected: got %h expected none", fs2ds_bus);
      end else begin
        chk("handoff", fs2ds_bus, q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    inst_sram_rdata = 32'b0;
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_zip     = 33'b0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_valid", 64'(fs2ds_valid), 64'd0);
    chk("rst_en", 64'(inst_sram_en), 64'd0);
    resetn = 1'b1;
    settle();
    chk("rel_en", 64'(inst_sram_en), 64'd0);

    step(); settle();
    chk("first_en", 64'(inst_sram_en), 64'd1);
    chk("first_addr", 64'(inst_sram_addr), 64'h1c000000);
    push(32'h1c000000);
    step(); settle();
    chk("seq_addr1", 64'(inst_sram_addr), 64'h1c000004);
    push(32'h1c000004);
    step(); settle();
    chk("seq_addr2", 64'(inst_sram_addr), 64'h1c000008);
    push(32'h1c000008);

    // stall with pc 1c000008 in fetch
    step();
    ds_allowin = 1'b0;
    settle();
    chk("stall_en", 64'(inst_sram_en), 64'd0);
    chk("stall_bus", fs2ds_bus, {32'h1c000008, 32'h02800421});
    repeat (2) begin
      step(); settle();
      chk("stall_en", 64'(inst_sram_en), 64'd0);
      chk("stall_bus", fs2ds_bus, {32'h1c000008, 32'h02800421});
    end
    step();
    ds_allowin = 1'b1;
    settle();
    chk("release_en", 64'(inst_sram_en), 64'd1);
    chk("release_addr", 64'(inst_sram_addr), 64'h1c00000c);
    push(32'h1c00000c);

    // redirect with fs_allowin high
    step();
    br_zip = {1'b1, 32'h1c000100};
    settle();
    chk("br_addr", 64'(inst_sram_addr), 64'h1c000100);
    chk("br_en", 64'(inst_sram_en), 64'd1);
    step();
    br_zip = 33'b0;
    push(32'h1c000100);
    settle();
    chk("br_next_addr", 64'(inst_sram_addr), 64'h1c000104);
    chk("br_valid", 64'(fs2ds_valid), 64'd1);
    step();
    push(32'h1c000104);
    settle();
    chk("br_seq_addr", 64'(inst_sram_addr), 64'h1c000108);

    // redirect during a stall
    step();
    ds_allowin = 1'b0;
    settle();
    chk("stall2_en", 64'(inst_sram_en), 64'd0);
    step();
    br_zip = {1'b1, 32'h1c000200};
    settle();
    chk("br_stall_en", 64'(inst_sram_en), 64'd0);
    step();
    br_zip = 33'b0;
    settle();
    chk("br_flush_valid", 64'(fs2ds_valid), 64'd0);
    chk("pend_en", 64'(inst_sram_en), 64'd1);
    chk("pend_addr", 64'(inst_sram_addr), 64'h1c000200);
    step();
    ds_allowin = 1'b1;
    push(32'h1c000200);
    settle();
    chk("pend_next", 64'(inst_sram_addr), 64'h1c000204);

    // second branch while a redirect is pending
    step();
    ds_allowin = 1'b0;
    settle();
    chk("stall3_en", 64'(inst_sram_en), 64'd0);
    step();
    br_zip = {1'b1, 32'h1c000280};
    settle();
    step();
    br_zip = {1'b1, 32'h1c000300};
    settle();
    chk("br2_valid", 64'(fs2ds_valid), 64'd0);
    chk("br2_en", 64'(inst_sram_en), 64'd1);
    chk("br2_addr", 64'(inst_sram_addr), 64'h1c000300);
    step();
    br_zip = 33'b0;
    ds_allowin = 1'b1;
    push(32'h1c000300);
    settle();
    chk("br2_next", 64'(inst_sram_addr), 64'h1c000304);

    // asynchronous reset between edges
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_valid", 64'(fs2ds_valid), 64'd0);
    chk("async_en", 64'(inst_sram_en), 64'd0);
    repeat (2) step();
    resetn = 1'b1;
    step(); settle();
    chk("restart_en", 64'(inst_sram_en), 64'd1);
    chk("restart_addr", 64'(inst_sram_addr), 64'h1c000000);
    push(32'h1c000000);
    step(); settle();
    chk("restart_next", 64'(inst_sram_addr), 64'h1c000004);
    step();
    ds_allowin = 1'b0;
    repeat (3) step();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
